gsensor_spi_responder: RTL

Synthesizable SPI responder (slave) emulating the accelerometer's register interface, i.e. the far end of the spi_control master. Lets the game and the accelerometer path run on a board or bench without a physical sensor: sample_x/y/z inputs (from switches or a test pattern) are presented as DATAX0..DATAZ1. Sits between a stimulus source and the GSENSOR_* pins/nets that spi_control drives.

---
 rtl/gsensor_pkg.sv | 47 ++++
 rtl/spi_edge_sync.sv | 47 ++++
 rtl/gsensor_spi_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gsensor_pkg.sv
// Shared definitions for the emulated accelerometer SPI register interface:
// register map, command bit positions, responder states and data-register helpers.
package gsensor_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int CMD_RW_BIT     = 7;
    localparam int CMD_MB_BIT     = 6;
    localparam int INT_DRDY_BIT   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } spi_resp_state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } sample_t;

    function automatic logic is_data_addr(input logic [5:0] addr);
        return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
    endfunction

    // Little-endian byte view of the sample: DATAX0 = x[7:0], DATAX1 = x[15:8], ...
    function automatic logic [7:0] sample_byte(input sample_t s, input logic [5:0] addr);
        case (addr)
            ADDR_DATAX0:         return s.x[7:0];
            ADDR_DATAX0 + 6'd1:  return s.x[15:8];
            ADDR_DATAX0 + 6'd2:  return s.y[7:0];
            ADDR_DATAX0 + 6'd3:  return s.y[15:8];
            ADDR_DATAX0 + 6'd4:  return s.z[7:0];
            ADDR_DATAX0 + 6'd5:  return s.z[15:8];
            default:             return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes asynchronous SPI pins into the clk domain and flags csn/sclk edges
// as single-cycle pulses; sdi is delivered through the same synchronizer depth.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic csn_i,
    input  logic sclk_i,
    input  logic sdi_i,
    output logic sdi_o,
    output logic csn_fall_o,
    output logic csn_rise_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   csn_prev_q;
    logic                   sclk_prev_q;

    // Idle bus levels (csn high, sclk high for CPOL=1) so leaving reset raises no edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '1;
            sdi_sync_q  <= '0;
            csn_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
            csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sdi_o       = sdi_sync_q[SYNC_STAGES-1];
    assign csn_fall_o  =  csn_prev_q  & ~csn_sync_q[SYNC_STAGES-1];
    assign csn_rise_o  = ~csn_prev_q  &  csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise_o = ~sclk_prev_q &  sclk_sync_q[SYNC_STAGES-1];
    assign sclk_fall_o =  sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder emulating the accelerometer register file, so the spi_control
// master can run without a physical sensor; samples come in through sample_x/y/z.
module gsensor_spi_responder
    import gsensor_pkg::*;
#(
    parameter logic [7:0] DEVID_VALUE = 8'hE5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    output logic        int1
);

    logic sdi_s, csn_fall, csn_rise, sclk_rise, sclk_fall;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .csn_i       (spi_csn),
        .sclk_i      (spi_sclk),
        .sdi_i       (spi_sdi),
        .sdi_o       (sdi_s),
        .csn_fall_o  (csn_fall),
        .csn_rise_o  (csn_rise),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall)
    );

    spi_resp_state_t state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [5:0]      addr_q, addr_d;
    logic            mb_q, mb_d;
    logic [6:0]      shift_q, shift_d;
    logic [7:0]      tx_q, tx_d;
    logic            sdo_q, sdo_d;
    logic            sdo_oe_q, sdo_oe_d;
    logic [7:0]      regfile_q [64];
    logic [7:0]      regfile_d [64];
    sample_t         shadow_q, shadow_d;
    sample_t         pending_q, pending_d;
    logic            pend_new_q, pend_new_d;
    logic            data_ready_q, data_ready_d;
    logic            data_read_q, data_read_d;

    logic [7:0] rx_byte;
    logic [5:0] cmd_addr;
    logic [5:0] next_addr;
    logic [7:0] cmd_rd_byte;
    logic [7:0] next_rd_byte;
    logic       ready_set;
    logic       ready_clr;

    assign rx_byte      = {shift_q, sdi_s};
    assign cmd_addr     = rx_byte[5:0];
    assign next_addr    = mb_q ? addr_q + 6'd1 : addr_q;
    assign cmd_rd_byte  = is_data_addr(cmd_addr)  ? sample_byte(shadow_q, cmd_addr)
                                                  : regfile_q[cmd_addr];
    assign next_rd_byte = is_data_addr(next_addr) ? sample_byte(shadow_q, next_addr)
                                                  : regfile_q[next_addr];

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        mb_d         = mb_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        sdo_d        = sdo_q;
        sdo_oe_d     = sdo_oe_q;
        regfile_d    = regfile_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_new_d   = pend_new_q;
        data_read_d  = data_read_q;
        ready_set    = 1'b0;
        ready_clr    = 1'b0;

        // Shadow only changes between transactions, keeping multi-byte reads coherent.
        if (sample_valid) begin
            pending_d  = {sample_x, sample_y, sample_z};
            pend_new_d = 1'b1;
        end
        if (sample_valid && state_q == IDLE) begin
            shadow_d   = {sample_x, sample_y, sample_z};
            pend_new_d = 1'b0;
            ready_set  = 1'b1;
        end else if (csn_fall && state_q == IDLE && pend_new_q) begin
            shadow_d   = pending_q;
            pend_new_d = 1'b0;
            ready_set  = 1'b1;
        end

        if (csn_rise) begin
            ready_clr   = (state_q != IDLE) && data_read_q;
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            addr_d      = 6'd0;
            mb_d        = 1'b0;
            shift_d     = 7'd0;
            tx_d        = 8'd0;
            sdo_d       = 1'b0;
            sdo_oe_d    = 1'b0;
            data_read_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = 3'd0;
                        shift_d   = 7'd0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = cmd_addr;
                            mb_d   = rx_byte[CMD_MB_BIT];
                            if (rx_byte[CMD_RW_BIT]) begin
                                state_d = RDATA;
                                tx_d    = cmd_rd_byte;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        sdo_d    = tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                        sdo_oe_d = 1'b1;
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (is_data_addr(addr_q)) begin
                                data_read_d = 1'b1;
                            end
                            addr_d = next_addr;
                            tx_d   = next_rd_byte;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            if (addr_q != ADDR_DEVID && !is_data_addr(addr_q)) begin
                                regfile_d[addr_q] = rx_byte;
                            end
                            addr_d = next_addr;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        data_ready_d = ready_set | (data_ready_q & ~ready_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            addr_q       <= 6'd0;
            mb_q         <= 1'b0;
            shift_q      <= 7'd0;
            tx_q         <= 8'd0;
            sdo_q        <= 1'b0;
            sdo_oe_q     <= 1'b0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_new_q   <= 1'b0;
            data_ready_q <= 1'b0;
            data_read_q  <= 1'b0;
            // NOTE: the register file is reset because its power-on contents are architecturally visible.
            for (int i = 0; i < 64; i++) begin
                regfile_q[i] <= 8'h00;
            end
            regfile_q[ADDR_DEVID]   <= DEVID_VALUE;
            regfile_q[ADDR_BW_RATE] <= BW_RATE_RST;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            mb_q         <= mb_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            sdo_q        <= sdo_d;
            sdo_oe_q     <= sdo_oe_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_new_q   <= pend_new_d;
            data_ready_q <= data_ready_d;
            data_read_q  <= data_read_d;
            regfile_q    <= regfile_d;
        end
    end

    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = sdo_oe_q;
    assign int1       = data_ready_q & regfile_q[ADDR_INT_ENABLE][INT_DRDY_BIT];

endmodule
